muldiv_unit: RTL and testbench

- Iterative multiply/divide execution unit for the RV32M instructions.
- Consumes the 5-bit ALU selection code produced by ALU control, plus both operands.
- Sits beside the combinational ALU in EX and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Uses a start/busy/done handshake; the hazard unit stalls the pipeline while busy=1.

---
 rtl/muldiv_unit_pkg.sv | 61 ++++++
 rtl/muldiv_unit_if.sv | 34 +++
 rtl/muldiv_unit_core.sv | 54 +++++
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the RV32M multiply/divide unit:
//   - ALU selection codes (the M-extension subset plus ALU_ADD, used to show
//     that non-M codes are rejected)
//   - FSM state encoding
//   - small decode helpers on the 5-bit ALU selection code
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_MUL    = 5'b10000;
    localparam logic [4:0] ALU_MULH   = 5'b10001;
    localparam logic [4:0] ALU_MULHSU = 5'b10010;
    localparam logic [4:0] ALU_MULHU  = 5'b10011;
    localparam logic [4:0] ALU_DIV    = 5'b10100;
    localparam logic [4:0] ALU_DIVU   = 5'b10101;
    localparam logic [4:0] ALU_REM    = 5'b10110;
    localparam logic [4:0] ALU_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // True for the eight RV32M operations only.
    function automatic logic is_m_op(input logic [4:0] op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_mul_op(input logic [4:0] op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    // Multiplies that return the upper word of the 2*XLEN product.
    function automatic logic is_high_op(input logic [4:0] op);
        return op inside {ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return op inside {ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_div_or_rem_op(input logic [4:0] op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    // rs1 is treated as signed for these operations.
    function automatic logic a_signed_op(input logic [4:0] op);
        return op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    // rs2 is treated as signed for these operations.
    function automatic logic b_signed_op(input logic [4:0] op);
        return op inside {ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle between the EX stage (master) and the
// multiply/divide unit (slave).
//   start  : request a new operation (only sampled while the unit is idle)
//   op     : 5-bit ALU selection code
//   a, b   : rs1 / rs2 operands
//   flush  : abandon any in-flight operation
//   busy   : operation in progress, pipeline must stall
//   done   : one-cycle pulse, result valid
//   result : final result, held until the next accepted start
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit_core.sv
// -----------------------------------------------------------------------------
// muldiv_unit_core
// One combinational iteration of the multiply/divide datapath.
//   mul_i     : 1 = shift-add multiply step, 0 = restoring divide step
//   hi_i/lo_i : working register pair
//               multiply: {partial product high, multiplier / product low}
//               divide  : {partial remainder, dividend / quotient}
//   operand_i : multiplicand (multiply) or divisor (divide), magnitudes
//   hi_o/lo_o : register pair after this step
// -----------------------------------------------------------------------------
module muldiv_unit_core #(
    parameter int XLEN = 32
) (
    input  logic            mul_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] operand_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN-1:0] addend;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        hi_o   = hi_i;
        lo_o   = lo_i;

        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift the whole 2*XLEN pair right by one, carry included.
        addend = lo_i[0] ? operand_i : '0;
        sum    = {1'b0, hi_i} + {1'b0, addend};

        // Divide: shift the next dividend bit into the XLEN+1 bit trial
        // remainder; a clear sign bit after subtracting means it fits.
        trial  = {hi_i, lo_i[XLEN-1]};
        diff   = trial - {1'b0, operand_i};

        if (mul_i) begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            hi_o = diff[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b1};
        end else begin
            hi_o = trial[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
// sitting beside the combinational ALU in EX.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (dominates start and flush)
//   bus : muldiv_unit_if slave (start/op/a/b/flush in, busy/done/result out)
// Operands are converted to magnitudes on acceptance, iterated for XLEN
// cycles, sign-corrected in one FIX cycle, then done pulses for one cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in one.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    md_state_e       state_q;
    logic [4:0]      op_q;
    logic            a_neg_q;     // dividend sign -> remainder sign
    logic            res_neg_q;   // operand signs differ -> negate product/quotient
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] operand_q;
    logic [XLEN-1:0] result_q;
    logic [CNT_W-1:0] count_q;
    logic            busy_q;
    logic            done_q;

    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;

    // Acceptance-time decode of the incoming request.
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_by_zero;
    logic            overflow;
    logic [XLEN-1:0] special_val;

    // Sign-corrected final values.
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        a_neg       = a_signed_op(bus.op) & bus.a[XLEN-1];
        b_neg       = b_signed_op(bus.op) & bus.b[XLEN-1];
        mag_a       = a_neg ? -bus.a : bus.a;
        mag_b       = b_neg ? -bus.b : bus.b;

        div_by_zero = is_div_or_rem_op(bus.op) && (bus.b == '0);
        overflow    = (bus.op == ALU_DIV || bus.op == ALU_REM) &&
                      (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);

        // Overflow needs b = -1, so the two cases never coincide.
        if (div_by_zero) begin
            special_val = is_rem_op(bus.op) ? bus.a : '1;
        end else begin
            special_val = is_rem_op(bus.op) ? '0 : bus.a;
        end
    end

    always_comb begin
        product   = {hi_q, lo_q};
        if (res_neg_q) begin
            product = -product;
        end
        quotient  = res_neg_q ? -lo_q : lo_q;
        remainder = a_neg_q   ? -hi_q : hi_q;

        if (is_mul_op(op_q)) begin
            fix_val = is_high_op(op_q) ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
        end else begin
            fix_val = is_rem_op(op_q) ? remainder : quotient;
        end
    end

    muldiv_unit_core #(
        .XLEN(XLEN)
    ) u_core (
        .mul_i     (is_mul_op(op_q)),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .operand_i (operand_q),
        .hi_o      (hi_d),
        .lo_o      (lo_d)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath is a handful of flops, not a memory, so it is
            // cleared along with the control state to keep reset fully defined.
            state_q   <= MD_IDLE;
            op_q      <= ALU_ADD;
            a_neg_q   <= 1'b0;
            res_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            operand_q <= '0;
            result_q  <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start && !bus.flush && is_m_op(bus.op)) begin
                        op_q      <= bus.op;
                        a_neg_q   <= a_neg;
                        res_neg_q <= a_neg ^ b_neg;
                        if (div_by_zero || overflow) begin
                            result_q <= special_val;
                            done_q   <= 1'b1;
                            state_q  <= MD_DONE;
                        end else begin
                            // Multiply iterates over the multiplier held in
                            // lo; divide shifts the dividend out of lo.
                            hi_q      <= '0;
                            lo_q      <= is_mul_op(bus.op) ? mag_b : mag_a;
                            operand_q <= is_mul_op(bus.op) ? mag_a : mag_b;
                            count_q   <= CNT_W'(XLEN - 1);
                            busy_q    <= 1'b1;
                            state_q   <= MD_CALC;
                        end
                    end
                end

                MD_CALC: begin
                    if (bus.flush) begin
                        busy_q  <= 1'b0;
                        state_q <= MD_IDLE;
                    end else begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                        if (count_q == '0) begin
                            state_q <= MD_FIX;
                        end else begin
                            count_q <= count_q - 1'b1;
                        end
                    end
                end

                MD_FIX: begin
                    busy_q <= 1'b0;
                    if (bus.flush) begin
                        state_q <= MD_IDLE;
                    end else begin
                        result_q <= fix_val;
                        done_q   <= 1'b1;
                        state_q  <= MD_DONE;
                    end
                end

                MD_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit. Cycle k is the clock period that
// follows the k-th rising edge after the accepting edge (edge 0); outputs are
// sampled on falling edges. Expected values come from directed constants or
// from a plain-arithmetic reference model of the RV32M rules.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN       = 32;
    localparam int NORMAL_LAT = XLEN + 2;
    localparam int MAX_WAIT   = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(
        .XLEN  (XLEN),
        .CNT_W (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [4:0] m_ops [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                              ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_model(input logic [4:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        int         ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            ALU_MUL:    begin p = ua * ub; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if ((op == ALU_DIV || op == ALU_DIVU || op == ALU_REM || op == ALU_REMU) && b == 0)
            return 1;
        if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return NORMAL_LAT;
    endfunction

    // ---------------- stimulus primitives ----------------
    // Returns just after the accepting edge (edge 0).
    task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
    endtask

    // Returns on the falling edge of the done cycle (done_cyc = 0 on timeout).
    task automatic wait_done(output logic [31:0] res, output int done_cyc, output int busy_cnt);
        done_cyc = 0;
        busy_cnt = 0;
        res      = 'x;
        for (int c = 1; c <= MAX_WAIT; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cyc = c;
                res      = bus.result;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = ALU_ADD;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
        else pass_cnt++;
        check_cnt++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done);
        else pass_cnt++;
        check_cnt++;
        if (bus.result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", bus.result);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        v [11];
        logic [31:0] res;
        int          dc, bc, exp_busy;
        v = '{
            '{ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
            '{ALU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34},
            '{ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
            '{ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34},
            '{ALU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34},
            '{ALU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34},
            '{ALU_DIVU,   32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 34},
            '{ALU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1},
            '{ALU_REMU,   32'd5,          32'd0,         32'd5,         1},
            '{ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1}
        };
        for (int i = 0; i < 11; i++) begin
            start_op(v[i].op, v[i].a, v[i].b);
            wait_done(res, dc, bc);
            exp_busy = (v[i].lat == 1) ? 0 : NORMAL_LAT - 1;
            check_cnt++;
            if (res !== v[i].exp) $display("FAIL directed[%0d]_result: got %h expected %h", i, res, v[i].exp);
            else pass_cnt++;
            check_cnt++;
            if (dc !== v[i].lat) $display("FAIL directed[%0d]_done_cycle: got %0d expected %0d", i, dc, v[i].lat);
            else pass_cnt++;
            check_cnt++;
            if (bc !== exp_busy) $display("FAIL directed[%0d]_busy_cycles: got %0d expected %0d", i, bc, exp_busy);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] a, b, res, exp;
        int          dc, bc, sel;
        for (int i = 0; i < 40; i++) begin
            op  = m_ops[$urandom_range(0, 7)];
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 100);
                default: ;
            endcase
            exp = ref_model(op, a, b);
            start_op(op, a, b);
            wait_done(res, dc, bc);
            check_cnt++;
            if (res !== exp) $display("FAIL random[%0d]_result op=%h a=%h b=%h: got %h expected %h", i, op, a, b, res, exp);
            else pass_cnt++;
            check_cnt++;
            if (dc !== ref_latency(op, a, b))
                $display("FAIL random[%0d]_done_cycle: got %0d expected %0d", i, dc, ref_latency(op, a, b));
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          dc, bc;
        bit          saw_done, saw_busy;
        start_op(ALU_DIVU, 32'd100, 32'd7);
        wait_done(res, dc, bc);
        check_cnt++;
        if (res !== 32'd14) $display("FAIL flush_setup_result: got %h expected 0000000e", res);
        else pass_cnt++;

        start_op(ALU_DIV, 32'hFFFF_0000, 32'd3);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1)  bus.start = 1'b0;
            if (c == 10) bus.flush = 1'b1;
        end
        @(negedge clk);
        bus.flush = 1'b0;
        check_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL flush_busy_after: got %b expected 0", bus.busy);
        else pass_cnt++;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
            if (bus.busy) saw_busy = 1'b1;
        end
        check_cnt++;
        if (saw_done !== 1'b0) $display("FAIL flush_no_done: got %b expected 0", saw_done);
        else pass_cnt++;
        check_cnt++;
        if (saw_busy !== 1'b0) $display("FAIL flush_stays_idle: got %b expected 0", saw_busy);
        else pass_cnt++;
        check_cnt++;
        if (bus.result !== 32'd14) $display("FAIL flush_result_kept: got %h expected 0000000e", bus.result);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        bit saw_done;
        start_op(ALU_MUL, 32'h1234_5678, 32'h0000_0003);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1)  bus.start = 1'b0;
            if (c == 20) rst = 1'b1;
        end
        @(negedge clk);
        check_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", bus.busy);
        else pass_cnt++;
        check_cnt++;
        if (bus.done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", bus.done);
        else pass_cnt++;
        check_cnt++;
        if (bus.result !== 32'h0) $display("FAIL rst_mid_result: got %h expected 00000000", bus.result);
        else pass_cnt++;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        check_cnt++;
        if (saw_done !== 1'b0) $display("FAIL rst_mid_no_done: got %b expected 0", saw_done);
        else pass_cnt++;
    endtask

    task automatic test_invalid_op();
        logic [31:0] res;
        int          dc, bc;
        bit          saw_done, saw_busy;
        start_op(ALU_REMU, 32'd5, 32'd0);
        wait_done(res, dc, bc);
        check_cnt++;
        if (res !== 32'd5) $display("FAIL invalid_setup_result: got %h expected 00000005", res);
        else pass_cnt++;

        // Non-M code: must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = ALU_ADD;
        bus.a     = $urandom;
        bus.b     = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
            if (bus.busy) saw_busy = 1'b1;
        end
        check_cnt++;
        if (saw_busy !== 1'b0) $display("FAIL invalid_op_busy: got %b expected 0", saw_busy);
        else pass_cnt++;
        check_cnt++;
        if (saw_done !== 1'b0) $display("FAIL invalid_op_done: got %b expected 0", saw_done);
        else pass_cnt++;
        check_cnt++;
        if (bus.result !== 32'd5) $display("FAIL invalid_op_result_kept: got %h expected 00000005", bus.result);
        else pass_cnt++;

        // Flush together with start in IDLE: not accepted.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = ALU_MUL;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
            if (bus.busy) saw_busy = 1'b1;
        end
        check_cnt++;
        if ((saw_busy | saw_done) !== 1'b0)
            $display("FAIL start_with_flush_ignored: busy=%b done=%b expected 0 0", saw_busy, saw_done);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        logic [31:0] a, b, exp, res;
        int          dc;
        a   = $urandom;
        b   = $urandom;
        exp = ref_model(ALU_MULHU, a, b);
        start_op(ALU_MULHU, a, b);
        dc  = 0;
        res = 'x;
        for (int c = 1; c <= MAX_WAIT; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c >= 5 && c <= 8) begin
                bus.start = 1'b1;
                bus.op    = ALU_DIV;
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
            if (c == 9) bus.start = 1'b0;
            if (bus.done) begin
                dc  = c;
                res = bus.result;
                break;
            end
        end
        check_cnt++;
        if (res !== exp) $display("FAIL busy_start_result: got %h expected %h", res, exp);
        else pass_cnt++;
        check_cnt++;
        if (dc !== NORMAL_LAT) $display("FAIL busy_start_done_cycle: got %0d expected %0d", dc, NORMAL_LAT);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, res;
        int          dc, bc;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom | 32'h1;
        start_op(ALU_MUL, a1, b1);
        wait_done(res, dc, bc);
        // Raise start during the done cycle and hold it.
        bus.start = 1'b1;
        bus.op    = ALU_REMU;
        bus.a     = a2;
        bus.b     = b2;
        check_cnt++;
        if (res !== ref_model(ALU_MUL, a1, b1))
            $display("FAIL b2b_first_result: got %h expected %h", res, ref_model(ALU_MUL, a1, b1));
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (bus.done !== 1'b0) $display("FAIL b2b_done_pulse: got %b expected 0", bus.done);
        else pass_cnt++;
        check_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL b2b_not_accepted_in_done: got %b expected 0", bus.busy);
        else pass_cnt++;
        @(posedge clk);
        wait_done(res, dc, bc);
        check_cnt++;
        if (res !== ref_model(ALU_REMU, a2, b2))
            $display("FAIL b2b_second_result: got %h expected %h", res, ref_model(ALU_REMU, a2, b2));
        else pass_cnt++;
        check_cnt++;
        if (dc !== NORMAL_LAT) $display("FAIL b2b_second_done_cycle: got %0d expected %0d", dc, NORMAL_LAT);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_rst_mid();
        test_invalid_op();
        test_start_while_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
